// File: rtl/alu181_seq.sv
// alu181_seq: slice-serial 74181-style ALU (16 arith + 16 logic functions) with valid/ready handshakes
module alu181_seq #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  input  logic             mode,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             cout,
  output logic             eq_ab,
  output logic             zero
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW = NSLICE > 1 ? $clog2(NSLICE) : 1;
  if (WIDTH < SLICE || WIDTH % SLICE != 0) begin : g_bad_width
    $error("alu181_seq: WIDTH must be a nonzero multiple of SLICE");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [1:0] rst_q;
  logic rst_i;
  logic [WIDTH-1:0] ra, rb, acc, acc_nx;
  logic [3:0] rsel;
  logic rmode, ext, last;
  logic [1:0] cy, cy_nx;
  logic [CW-1:0] cnt;
  logic [SLICE-1:0] as, bs, x, y, lf, res;
  logic [SLICE+1:0] s;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rst_q <= 2'b00;
    else rst_q <= {rst_q[0], 1'b1};
  assign rst_i = rst_q[1];
  assign as = ra[SLICE-1:0];
  assign bs = rb[SLICE-1:0];
  assign last = cnt == CW'(NSLICE - 1);
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  // Arithmetic is x + y + carry; ext marks a y that is negative in WIDTH+1 bits (-1 or -B)
  always_comb begin
    x = as;
    y = '0;
    ext = 1'b0;
    case (rsel)
      4'h1: x = as | bs;
      4'h2: x = as | ~bs;
      4'h3: begin x = '0; y = '1; ext = 1'b1; end
      4'h4: y = as & ~bs;
      4'h5: begin x = as | bs; y = as & ~bs; end
      4'h6: begin y = ~bs; ext = 1'b1; end
      4'h7: begin x = as & ~bs; y = '1; ext = 1'b1; end
      4'h8: y = as & bs;
      4'h9: y = bs;
      4'ha: begin x = as | ~bs; y = as & bs; end
      4'hb: begin x = as & bs; y = '1; ext = 1'b1; end
      4'hc: y = as;
      4'hd: begin x = as | bs; y = as; end
      4'he: begin x = as | ~bs; y = as; end
      4'hf: begin y = '1; ext = 1'b1; end
      default: ;
    endcase
  end
  always_comb begin
    lf = as;
    case (rsel)
      4'h0: lf = ~as;
      4'h1: lf = ~(as | bs);
      4'h2: lf = ~as & bs;
      4'h3: lf = '0;
      4'h4: lf = ~(as & bs);
      4'h5: lf = ~bs;
      4'h6: lf = as ^ bs;
      4'h7: lf = as & ~bs;
      4'h8: lf = ~as | bs;
      4'h9: lf = as ~^ bs;
      4'ha: lf = bs;
      4'hb: lf = as & bs;
      4'hc: lf = '1;
      4'hd: lf = as | ~bs;
      4'he: lf = as | bs;
      default: lf = as;
    endcase
  end
  assign s = {2'b00, x} + {2'b00, y} + {{SLICE{1'b0}}, cy};
  assign res = rmode ? lf : s[SLICE-1:0];
  assign cy_nx = s[SLICE+1:SLICE];
  assign acc_nx = (acc >> SLICE) | (WIDTH'(res) << (WIDTH - SLICE));
  always_ff @(posedge clk or negedge rst_i)
    if (!rst_i) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = in_valid ? RUN : IDLE;
      RUN: state_nx = last ? DONE : RUN;
      DONE: state_nx = out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  // A-B+c is A + ~B + 1 + c, so the initial carry may be 2
  always_ff @(posedge clk or negedge rst_i)
    if (!rst_i) begin
      ra <= '0;
      rb <= '0;
      rsel <= '0;
      rmode <= 1'b0;
      cy <= '0;
      cnt <= '0;
      acc <= '0;
      f <= '0;
      cout <= 1'b0;
      eq_ab <= 1'b0;
      zero <= 1'b1;
    end else if (state == IDLE && in_valid) begin
      ra <= a;
      rb <= b;
      rsel <= sel;
      rmode <= mode;
      cy <= {1'b0, ~cin} + {1'b0, ~mode && sel == 4'h6};
      cnt <= '0;
    end else if (state == RUN) begin
      ra <= ra >> SLICE;
      rb <= rb >> SLICE;
      cy <= cy_nx;
      acc <= acc_nx;
      cnt <= cnt + CW'(1);
      if (last) begin
        f <= acc_nx;
        cout <= ~rmode & (ext ^ cy_nx[0]);
        eq_ab <= &acc_nx;
        zero <= ~|acc_nx;
      end
    end
endmodule

// File: tb/tb_alu181_seq.sv
// tb_alu181_seq: scoreboard bench for alu181_seq, directed 16-bit vectors plus a 4/8/32-bit model sweep
module tb_alu181_seq;
  logic clk = 0, rst_n = 1, sw_rst_n = 1, sw_go = 0;
  logic in_valid = 0, out_ready = 1, mode = 0, cin = 0;
  logic [15:0] a = 0, b = 0;
  logic [3:0] sel = 0;
  logic in_ready, out_valid, cout, eq_ab, zero;
  logic [15:0] f;
  int checks = 0, errors = 0, cyc = 0, acc_cyc = 0, sw_done = 0;
  logic pov = 0;
  logic [18:0] q[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  alu181_seq #(.WIDTH(16), .SLICE(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .sel(sel), .mode(mode), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .f(f), .cout(cout), .eq_ab(eq_ab), .zero(zero)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (in_valid && in_ready) acc_cyc = cyc;
    if (out_valid && !pov) chk("latency", 64'(cyc - acc_cyc - 1), 64'd4);
    pov = out_valid;
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got f=0x%0h with empty scoreboard", f);
      end else chk("result", {f, cout, eq_ab, zero}, q.pop_front());
    end
  end
  task automatic send(input logic [15:0] ta, tb2, input logic [3:0] ts, input logic tm, tc,
                      input logic [15:0] ef, input logic ec);
    int n = 0;
    q.push_back({ef, ec, &ef, ef == 16'h0});
    a = ta; b = tb2; sel = ts; mode = tm; cin = tc; in_valid = 1;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("accept_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 0; a = 16'($urandom); b = 16'($urandom); sel = 4'($urandom); mode = 1'($urandom); cin = 1'($urandom);
  endtask
  task automatic drain;
    int n = 0;
    while (q.size() != 0 && n < 60) begin @(posedge clk); n++; end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending, want 0", q.size());
      q.delete();
    end
    #1;
  endtask
  task automatic op(input logic [15:0] ta, tb2, input logic [3:0] ts, input logic tm, tc,
                    input logic [15:0] ef, input logic ec);
    send(ta, tb2, ts, tm, tc, ef, ec);
    drain();
  endtask
  for (genvar g = 0; g < 3; g++) begin : sw
    localparam int W = g == 0 ? 4 : g == 1 ? 8 : 32;
    localparam logic [W:0] M1 = '1;
    logic iv = 0, ir, ov, co, eq, zr, sm = 0, sc = 0, spov = 0;
    logic [W-1:0] sa = 0, sb = 0, sf;
    logic [3:0] ss = 0;
    logic [W+2:0] sq[$];
    int sacc = 0;
    alu181_seq #(.WIDTH(W), .SLICE(4)) dut (
      .clk(clk), .rst_n(sw_rst_n), .in_valid(iv), .in_ready(ir), .a(sa), .b(sb),
      .sel(ss), .mode(sm), .cin(sc), .out_valid(ov), .out_ready(1'b1),
      .f(sf), .cout(co), .eq_ab(eq), .zero(zr)
    );
    function automatic logic [W+2:0] model(input logic [W-1:0] x, y, input logic [3:0] s, input logic m, ci);
      logic [W:0] ax, bx, o, on, an, nd, c, r;
      logic [W-1:0] l;
      ax = {1'b0, x}; bx = {1'b0, y}; o = {1'b0, x | y}; on = {1'b0, x | ~y};
      an = {1'b0, x & ~y}; nd = {1'b0, x & y}; c = {{W{1'b0}}, ~ci};
      case (s)
        4'd0: r = ax + c;       4'd1: r = o + c;        4'd2: r = on + c;       4'd3: r = M1 + c;
        4'd4: r = ax + an + c;  4'd5: r = o + an + c;   4'd6: r = ax - bx + c;  4'd7: r = an + M1 + c;
        4'd8: r = ax + nd + c;  4'd9: r = ax + bx + c;  4'd10: r = on + nd + c; 4'd11: r = nd + M1 + c;
        4'd12: r = ax + ax + c; 4'd13: r = o + ax + c;  4'd14: r = on + ax + c; default: r = ax + M1 + c;
      endcase
      case (s)
        4'd0: l = ~x;        4'd1: l = ~(x | y);  4'd2: l = ~x & y;    4'd3: l = '0;
        4'd4: l = ~(x & y);  4'd5: l = ~y;        4'd6: l = x ^ y;     4'd7: l = x & ~y;
        4'd8: l = ~x | y;    4'd9: l = x ~^ y;    4'd10: l = y;        4'd11: l = x & y;
        4'd12: l = '1;       4'd13: l = x | ~y;   4'd14: l = x | y;    default: l = x;
      endcase
      if (m) r = {1'b0, l};
      return {r[W-1:0], r[W], &r[W-1:0], ~|r[W-1:0]};
    endfunction
    always @(negedge clk) begin
      if (iv && ir) sacc = cyc;
      if (ov && !spov) chk($sformatf("latency_w%0d", W), 64'(cyc - sacc - 1), 64'(W / 4));
      spov = ov;
      if (ov) begin
        if (sq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out_w%0d: got f=0x%0h with empty scoreboard", W, sf);
        end else chk($sformatf("sweep_w%0d", W), 64'({sf, co, eq, zr}), 64'(sq.pop_front()));
      end
    end
    initial begin
      while (!sw_go) @(posedge clk);
      #1;
      repeat (12) begin
        int n = 0;
        sa = W'($urandom); sb = W'($urandom); ss = 4'($urandom); sm = 1'($urandom); sc = 1'($urandom);
        sq.push_back(model(sa, sb, ss, sm, sc));
        iv = 1;
        while (!ir && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        iv = 0;
        n = 0;
        while (sq.size() != 0 && n < 100) begin @(posedge clk); n++; end
        if (sq.size() != 0) begin
          checks++;
          errors++;
          $display("FAIL sweep_timeout_w%0d: got %0d pending, want 0", W, sq.size());
          sq.delete();
        end
        #1;
      end
      sw_done++;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal;
  end
  initial begin
    int n;
    #1 rst_n = 0; sw_rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_f", f, 0);
    chk("reset_cout", cout, 0);
    chk("reset_eq_ab", eq_ab, 0);
    chk("reset_zero", zero, 1);
    #2 rst_n = 1; sw_rst_n = 1;
    repeat (4) @(posedge clk);
    #1 sw_go = 1;
    op(16'h1234, 16'h0FFF, 4'h9, 0, 1, 16'h2233, 0);
    op(16'hFFFF, 16'h0001, 4'h9, 0, 0, 16'h0001, 1);
    op(16'h0003, 16'h0004, 4'h6, 0, 1, 16'hFFFF, 1);
    op(16'h0005, 16'h0005, 4'h6, 0, 1, 16'h0000, 0);
    op(16'hAAAA, 16'h5555, 4'h3, 0, 1, 16'hFFFF, 1);
    op(16'hF0F0, 16'hFF00, 4'h6, 1, 1, 16'h0FF0, 0);
    op(16'hAAAA, 16'h5555, 4'h3, 0, 0, 16'h0000, 0);
    op(16'h8001, 16'h0000, 4'hC, 0, 0, 16'h0003, 1);
    op(16'h1234, 16'h0000, 4'h0, 1, 1, 16'hEDCB, 0);
    op(16'h1234, 16'h0234, 4'h6, 0, 0, 16'h1001, 0);
    op(16'h00F0, 16'h0030, 4'h7, 0, 1, 16'h00BF, 0);
    op(16'hFFFF, 16'h0000, 4'h0, 0, 0, 16'h0000, 1);
    op(16'h0000, 16'h0000, 4'hF, 0, 1, 16'hFFFF, 1);
    op(16'hABCD, 16'h1234, 4'hC, 1, 0, 16'hFFFF, 0);
    op(16'h00F0, 16'h0F00, 4'h5, 0, 1, 16'h10E0, 0);
    op(16'h000F, 16'hFFF0, 4'hA, 0, 1, 16'h000F, 0);
    out_ready = 0;
    send(16'h1234, 16'h0FFF, 4'h9, 0, 1, 16'h2233, 0);
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    repeat (5) begin
      in_valid = 1; a = 16'($urandom); b = 16'($urandom);
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_f", f, 16'h2233);
      @(posedge clk); #1;
    end
    a = 16'h0003; b = 16'h0004; sel = 4'h6; mode = 0; cin = 1;
    q.push_back({16'hFFFF, 1'b1, 1'b1, 1'b0});
    out_ready = 1;
    @(negedge clk);
    chk("bp_no_accept_in_done", in_ready, 0);
    @(posedge clk); #1;
    chk("bp_idle_next", {in_ready, out_valid}, 2'b10);
    @(posedge clk); #1;
    in_valid = 0;
    chk("bp_accepted", in_ready, 0);
    drain();
    send(16'h1234, 16'h0FFF, 4'h9, 0, 1, 16'h2233, 0);
    @(posedge clk);
    @(posedge clk);
    #2 chk("run_hold_f", f, 16'hFFFF);
    rst_n = 0;
    q.delete();
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_f", f, 0);
    chk("midrst_zero", zero, 1);
    chk("midrst_cout", cout, 0);
    @(negedge clk) rst_n = 1;
    #1 chk("midrst_in_ready", in_ready, 1);
    repeat (3) @(posedge clk);
    #1;
    op(16'hFFFF, 16'h0001, 4'h9, 0, 0, 16'h0001, 1);
    n = 0;
    while (sw_done < 3 && n < 3000) begin @(posedge clk); n++; end
    chk("sweep_complete", sw_done, 3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
